// File: rtl/packet_framer_if.sv
// packet_framer_if: payload byte input and framed word output channels.
// FRAMER_LOSS_INJECT_EN adds the injectLoss control on the byte side.
interface packet_framer_if;
    logic [7:0]  byteIn;
    logic        byteIn_val;
    logic        byteIn_last;
    logic [15:0] streamId;
    logic        byteIn_ready;
    logic [31:0] dataOut;
    logic        dataOut_val;
    logic        dataOut_last;
    logic        dataOut_ready;
    logic        overflow;
`ifdef FRAMER_LOSS_INJECT_EN
    logic        injectLoss;

    modport master (
        output byteIn, byteIn_val, byteIn_last, streamId, injectLoss,
        output dataOut_ready,
        input  byteIn_ready, dataOut, dataOut_val, dataOut_last, overflow
    );

    modport slave (
        input  byteIn, byteIn_val, byteIn_last, streamId, injectLoss,
        input  dataOut_ready,
        output byteIn_ready, dataOut, dataOut_val, dataOut_last, overflow
    );
`else
    modport master (
        output byteIn, byteIn_val, byteIn_last, streamId,
        output dataOut_ready,
        input  byteIn_ready, dataOut, dataOut_val, dataOut_last, overflow
    );

    modport slave (
        input  byteIn, byteIn_val, byteIn_last, streamId,
        input  dataOut_ready,
        output byteIn_ready, dataOut, dataOut_val, dataOut_last, overflow
    );
`endif
endinterface

// File: rtl/packet_framer.sv
// packet_framer: packs payload bytes into {len,sid}, seq, big-endian words.
// Optional macro FRAMER_LOSS_INJECT_EN: injectLoss skips one seq number.
module packet_framer #(
    parameter int MAX_PAYLOAD = 37,
    parameter int NUM_STREAMS = 32
) (
    input logic            clk,
    input logic            reset_b,
    packet_framer_if.slave bus
);
    localparam int CW = $clog2(MAX_PAYLOAD + 1);
    localparam int MAX_WORDS = (MAX_PAYLOAD + 3) / 4;
    localparam int WW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    typedef enum logic [1:0] {COLLECT, HDR0, HDR1, DATA} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    buf_q [MAX_PAYLOAD];
    logic [7:0]    buf_d [MAX_PAYLOAD];
    logic [15:0]   sid_q, sid_d;
    logic [31:0]   seq_q, seq_d;
    logic [31:0]   ctr_q [NUM_STREAMS];
    logic [31:0]   ctr_d [NUM_STREAMS];
    logic [WW-1:0] widx_q, widx_d;
    logic          ovf_q, ovf_d;

    logic          in_ready, out_val, out_last;
    logic [31:0]   out_data, data_word, step;
    logic          byte_acc, word_acc, last_word;
    logic [15:0]   cur_sid;
    logic [IW-1:0] cur_idx;

`ifdef FRAMER_LOSS_INJECT_EN
    assign step = bus.injectLoss ? 32'd2 : 32'd1;
`else
    assign step = 32'd1;
`endif

    assign byte_acc = bus.byteIn_val & in_ready;
    assign word_acc = out_val & bus.dataOut_ready;
    // streamId is only live on the first byte; later bytes use the latch
    assign cur_sid = (count_q == '0) ? bus.streamId : sid_q;
    assign cur_idx = cur_sid[IW-1:0];
    assign last_word = (int'(widx_q) + 1) * 4 >= int'(count_q);

    always_comb begin
        data_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (CW'(4 * int'(widx_q) + b) < count_q) begin
                data_word[31 - 8*b -: 8] = buf_q[CW'(4 * int'(widx_q) + b)];
            end
        end
    end

    always_comb begin
        in_ready = 1'b0;
        out_val  = 1'b0;
        out_last = 1'b0;
        out_data = '0;
        unique case (state_q)
            COLLECT: in_ready = 1'b1;
            HDR0: begin
                out_val  = 1'b1;
                out_data = {16'(count_q) + 16'd8, sid_q};
            end
            HDR1: begin
                out_val  = 1'b1;
                out_data = seq_q;
            end
            DATA: begin
                out_val  = 1'b1;
                out_data = data_word;
                out_last = last_word;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        buf_d   = buf_q;
        sid_d   = sid_q;
        seq_d   = seq_q;
        ctr_d   = ctr_q;
        widx_d  = widx_q;
        ovf_d   = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (byte_acc) begin
                    buf_d[count_q] = bus.byteIn;
                    count_d = count_q + CW'(1);
                    sid_d = cur_sid;
                    if (bus.byteIn_last ||
                        count_q == CW'(MAX_PAYLOAD - 1)) begin
                        ovf_d = ~bus.byteIn_last;
                        seq_d = ctr_q[cur_idx] + step;
                        ctr_d[cur_idx] = seq_d;
                        widx_d = '0;
                        state_d = HDR0;
                    end
                end
            end
            HDR0: if (word_acc) state_d = HDR1;
            HDR1: if (word_acc) state_d = DATA;
            DATA: begin
                if (word_acc) begin
                    if (last_word) begin
                        state_d = COLLECT;
                        count_d = '0;
                    end else begin
                        widx_d = widx_q + WW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q <= COLLECT;
            count_q <= '0;
            sid_q   <= '0;
            seq_q   <= '0;
            widx_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < MAX_PAYLOAD; i++) buf_q[i] <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) ctr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sid_q   <= sid_d;
            seq_q   <= seq_d;
            widx_q  <= widx_d;
            ovf_q   <= ovf_d;
            buf_q   <= buf_d;
            ctr_q   <= ctr_d;
        end
    end

    assign bus.byteIn_ready = in_ready;
    assign bus.dataOut      = out_data;
    assign bus.dataOut_val  = out_val;
    assign bus.dataOut_last = out_last;
    assign bus.overflow     = ovf_q;
endmodule

// File: doc/packet_framer.md
Name: packet_framer

Overview:
Upstream neighbour of the sequence parser; builds the framed 32-bit word stream that the parser consumes. It collects a payload byte stream per packet, then emits two header words and the packed payload:
- word0 = {length[15:0], streamId[15:0]}, where length counts bytes incl. the 8-byte header;
- word1 = 32-bit sequence number;
- payload words, big-endian.
Keeps a per-stream sequence counter so a lossless link yields seq = previous + 1 at the parser.

Parameters:
MAX_PAYLOAD, 37, max payload bytes per packet (matches parser's 296-bit output)
NUM_STREAMS, 32, number of per-stream sequence counters; power of 2; index = streamId[log2(NUM_STREAMS)-1:0]

Ports:
clk  in  1  clock
reset_b  in  1  synchronous active-low reset
byteIn  in  8  payload byte
byteIn_val  in  1  byteIn valid
byteIn_last  in  1  final byte of packet, qualified by byteIn_val
streamId  in  16  stream of current packet; sampled with the first accepted byte
byteIn_ready  out  1  framer can accept a byte
dataOut  out  32  framed word to parser
dataOut_val  out  1  dataOut valid
dataOut_last  out  1  final word of packet (drives parser dataIN_last)
dataOut_ready  in  1  downstream accepts word
overflow  out  1  one-cycle pulse: packet truncated at MAX_PAYLOAD

Behaviour:
- Reset (reset_b=0 at posedge):
  - state=COLLECT, byte count=0, buffer zeroed, all seq counters=0.
  - dataOut_val=0, dataOut_last=0, dataOut=0, overflow=0, byteIn_ready=1 from next cycle.
  - Reset mid-packet discards the packet; no partial words are emitted afterwards.
- Byte accept = byteIn_val & byteIn_ready. Word accept = dataOut_val & dataOut_ready.
- COLLECT:
  - byteIn_ready=1.
  - Each accepted byte is stored at buffer[count]; count increments.
  - The first byte latches streamId.
  - On an accepted byte with byteIn_last=1: go to HDR0.
  - If count reaches MAX_PAYLOAD without last, the MAX_PAYLOAD-th byte is treated as last, overflow pulses one cycle, and the state goes to HDR0. Subsequent input bytes start a new packet.
- On COLLECT->HDR0, the sequence counter of the latched stream index is incremented (32-bit wrap 0xFFFFFFFF->0) and latched as the packet seq. The first packet on a stream after reset carries seq=1.
- HDR0: dataOut={8+count, streamId}, val=1. HDR1: dataOut=seq. DATA: words k=0..ceil(count/4)-1, with buffer[4k] in bits [31:24].
- Unused bytes of the final word are 0. dataOut_last=1 only on the final DATA word.
- A zero-length payload cannot occur: last always accompanies a byte.
- Each state advances only on word accept. While val=1 and ready=0, dataOut and dataOut_last are held stable.
- After the final word accept: back to COLLECT, count=0, byteIn_ready=1 in the next cycle.
- byteIn_ready=0 in HDR0/HDR1/DATA. There is no overlap between packets.
- Latency: the cycle after the last-byte accept, dataOut_val=1 with word0. With ready held high, one word is emitted per cycle.
- streamId bits above the index width are carried in word0 but alias to the same counter (stream 35 shares the counter of stream 3 when NUM_STREAMS=32).

Optional Feature:
Macro FRAMER_LOSS_INJECT_EN.
- Defined: adds input injectLoss (1 bit), sampled on the last-byte accept. If 1, the stream counter advances by 2 and the packet carries the advanced value, so the parser sees a gap.
- Undefined: no port; counter always advances by 1.

Test Plan:
1. Stream 3, bytes AA BB CC DD EE (EE last), ready=1 -> words 0x000D0003, 0x00000001, 0xAABBCCDD, 0xEE000000 with last=1 on the 4th word; byteIn_ready=1 the next cycle.
2. Second packet on stream 3, single byte 11 -> 0x00090003, 0x00000002, 0x11000000 (last); then stream 35, byte 22 -> 0x00090023, 0x00000003.
3. dataOut_ready low for 5 cycles on word1 of test 1 -> word1 held at 0x00000001, val=1, byteIn_ready=0 throughout; the sequence resumes unchanged.
4. 40 bytes 0x00..0x27 on stream 1, no last until the 40th -> overflow pulse on the 37th byte; packet length 0x002D with 10 data words, the last being 0x24000000. Bytes 0x25..0x27 form the next packet: length 0x000B, seq 2.
5. Assert reset_b=0 during the DATA state of a packet -> val=0 next cycle; all counters cleared; next packet on stream 3 carries seq 1.
6. (FRAMER_LOSS_INJECT_EN) injectLoss=1 on the second packet of stream 5 -> seqs 1 then 3; the next packet without injection carries 4.
